// File: rtl/clock_monitor.sv
// clock_monitor
// Frequency checker for a derived clock. Runs on the reference clock and treats
// mon_clk as an asynchronous data input. It synchronizes mon_clk, counts rising
// edges over WINDOW reference cycles and reports the count plus an in-tolerance
// status.
//
// Ports
//   clk         reference clock, all logic on rising edge
//   reset_n     asynchronous active-low reset
//   enable      1 = measure, 0 = idle (synchronous)
//   mon_clk     monitored clock, asynchronous, at most f(clk)/4
//   count       edges counted in the last completed window
//   count_valid one-cycle pulse when count updates
//   freq_ok     two consecutive windows within EXP_COUNT +/- TOL
//   stalled     last completed window saw zero edges
module clock_monitor #(
  parameter int unsigned WINDOW    = 1024,
  parameter int unsigned CNT_W     = 11,
  parameter int unsigned EXP_COUNT = 256,
  parameter int unsigned TOL       = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             mon_clk,
  output logic [CNT_W-1:0] count,
  output logic             count_valid,
  output logic             freq_ok,
  output logic             stalled
);

  localparam int unsigned     WinW    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [WinW-1:0] WinLast = WinW'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W:0]  ExpW    = (CNT_W + 1)'(EXP_COUNT);
  localparam logic [CNT_W:0]  TolW    = (CNT_W + 1)'(TOL);

  typedef enum logic [1:0] {StIdle, StSettle, StMeasure} state_e;

  state_e           state_q, state_d;
  logic [1:0]       settle_q, settle_d;
  logic [WinW-1:0]  win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             count_valid_q, count_valid_d;
  logic             freq_ok_q, freq_ok_d;
  logic             stalled_q, stalled_d;
  logic             prev_good_q, prev_good_d;

  logic             sync1_q, sync2_q, sync3_q;
  logic             rise;
  logic             terminal;
  logic [CNT_W-1:0] edge_sum;
  logic [CNT_W:0]   total_ext;
  logic [CNT_W:0]   dev;
  logic             in_range;

  // Synchronizer; sync3 only serves edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= mon_clk;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign rise = sync2_q & ~sync3_q;

  // Saturating count including this cycle's edge; on the terminal cycle this
  // is the window total.
  assign edge_sum = (edge_cnt_q == CntMax) ? CntMax : edge_cnt_q + CNT_W'(rise);

  // Absolute deviation one bit wider than the counter so it cannot wrap.
  assign total_ext = {1'b0, edge_sum};
  assign dev       = (total_ext >= ExpW) ? (total_ext - ExpW) : (ExpW - total_ext);
  assign in_range  = (dev <= TolW);

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:    state_d = StSettle;
        StSettle:  if (settle_q == 2'd2) state_d = StMeasure;
        StMeasure: state_d = StMeasure;
        default:   state_d = StIdle;
      endcase
    end
  end

  // FSM outputs: counters advance only while enabled; anything else clears them.
  always_comb begin
    settle_d   = '0;
    win_cnt_d  = '0;
    edge_cnt_d = '0;
    terminal   = 1'b0;
    if (enable) begin
      unique case (state_q)
        StSettle: settle_d = settle_q + 2'd1;
        StMeasure: begin
          if (win_cnt_q == WinLast) begin
            // Counters restart so the next window begins next cycle, no gap.
            terminal = 1'b1;
          end else begin
            win_cnt_d  = win_cnt_q + WinW'(1);
            edge_cnt_d = edge_sum;
          end
        end
        default: ;
      endcase
    end
  end

  // Result next state
  always_comb begin
    count_d       = count_q;
    count_valid_d = 1'b0;
    stalled_d     = stalled_q;
    freq_ok_d     = freq_ok_q;
    prev_good_d   = prev_good_q;
    if (!enable) begin
      freq_ok_d   = 1'b0;
      prev_good_d = 1'b0;
    end else if (terminal) begin
      count_d       = edge_sum;
      count_valid_d = 1'b1;
      stalled_d     = (edge_sum == '0);
      if (in_range) begin
        freq_ok_d   = freq_ok_q | prev_good_q;
        prev_good_d = 1'b1;
      end else begin
        freq_ok_d   = 1'b0;
        prev_good_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      settle_q      <= '0;
      win_cnt_q     <= '0;
      edge_cnt_q    <= '0;
      count_q       <= '0;
      count_valid_q <= 1'b0;
      stalled_q     <= 1'b0;
      freq_ok_q     <= 1'b0;
      prev_good_q   <= 1'b0;
    end else begin
      settle_q      <= settle_d;
      win_cnt_q     <= win_cnt_d;
      edge_cnt_q    <= edge_cnt_d;
      count_q       <= count_d;
      count_valid_q <= count_valid_d;
      stalled_q     <= stalled_d;
      freq_ok_q     <= freq_ok_d;
      prev_good_q   <= prev_good_d;
    end
  end

  assign count       = count_q;
  assign count_valid = count_valid_q;
  assign freq_ok     = freq_ok_q;
  assign stalled     = stalled_q;

endmodule
